// File: rtl/job_seq_ctrl_if.sv
// Host-side bundle for job_seq_ctrl: host job controls, the request
// handshake, and the status and pulse outputs of the controller.
interface job_seq_ctrl_if;
  logic go;
  logic abort;
  logic fault;
  logic req;
  logic rdy;
  logic start;
  logic endd;
  logic stop;
  logic er;
  logic interrupt;
  logic ack;
  logic busy;

  // Host drives the job controls and the request, and observes the status.
  modport master (
    output go, abort, fault, req,
    input  rdy, start, endd, stop, er, interrupt, ack, busy
  );

  // The controller observes the job controls and the request, and drives the status.
  modport slave (
    input  go, abort, fault, req,
    output rdy, start, endd, stop, er, interrupt, ack, busy
  );
endinterface

// File: rtl/job_seq_ctrl.sv
// Job sequencing controller: turns host go/abort/fault/req into a job
// lifecycle pulse stream. Every output is a decode of registered state.
// Optional feature macro: JOB_IRQ_EN. When it is defined, the interrupt
// output is driven. When it is undefined, interrupt is tied to 0.
//
// state | meaning
// INIT  | first cycle out of reset, all outputs 0
// IDLE  | rdy=1, waits for go
// START | one-cycle start pulse, loads run timer, clears since_start
// RUN   | job running, down-counts run timer
// END   | one-cycle normal-completion pulse
// STOP  | one-cycle abort pulse
// ERR   | er=1 while fault persists, at most ERR_MAX cycles
// HOLD  | cool-down until since_start reaches COOL_CYCLES
module job_seq_ctrl #(
  parameter int RUN_CYCLES  = 8,
  parameter int COOL_CYCLES = 10,
  parameter int ERR_MAX     = 3,
  parameter int ACK_LAT     = 5
) (
  input logic           clk,
  input logic           rst,
  job_seq_ctrl_if.slave bus
);

  localparam int RW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam int EW = (ERR_MAX > 1) ? $clog2(ERR_MAX) : 1;
  localparam int SW = $clog2(COOL_CYCLES + 1) + 1;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_START, ST_RUN, ST_END, ST_STOP, ST_ERR, ST_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        run_cnt_q, run_cnt_d;
  logic [EW-1:0]        err_cnt_q, err_cnt_d;
  logic [SW-1:0]        since_q, since_d;
  logic [ACK_LAT-1:0]   ack_sr_q, ack_sr_d;

  // State, counters and ack delay line; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      run_cnt_q <= '0;
      err_cnt_q <= '0;
      since_q   <= '0;
      ack_sr_q  <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      err_cnt_q <= err_cnt_d;
      since_q   <= since_d;
      ack_sr_q  <= ack_sr_d;
    end
  end

  // Next-state and counter updates; RUN priority is fault > abort > timer done.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    err_cnt_d = err_cnt_q;
    since_d   = (since_q == '1) ? since_q : since_q + 1'b1;
    case (state_q)
      ST_INIT:  state_d = ST_IDLE;
      ST_IDLE:  if (bus.go) state_d = ST_START;
      ST_START: begin
        run_cnt_d = RW'(RUN_CYCLES - 1);
        since_d   = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (bus.fault) begin
          state_d   = ST_ERR;
          err_cnt_d = '0;
        end else if (bus.abort) begin
          state_d = ST_STOP;
        end else if (run_cnt_q == '0) begin
          state_d = ST_END;
        end else begin
          run_cnt_d = run_cnt_q - 1'b1;
        end
      end
      ST_END:   state_d = ST_HOLD;
      ST_STOP:  state_d = ST_HOLD;
      ST_ERR: begin
        if (!bus.fault || err_cnt_q == EW'(ERR_MAX - 1)) state_d = ST_HOLD;
        else err_cnt_d = err_cnt_q + 1'b1;
      end
      ST_HOLD:  if (since_q >= SW'(COOL_CYCLES)) state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  // Request delay line: ack repeats req exactly ACK_LAT cycles later.
  always_comb begin
    ack_sr_d    = ack_sr_q << 1;
    ack_sr_d[0] = bus.req;
  end

  // Moore output decode from registered state.
  always_comb begin
    bus.rdy   = (state_q == ST_IDLE);
    bus.start = (state_q == ST_START);
    bus.endd  = (state_q == ST_END);
    bus.stop  = (state_q == ST_STOP);
    bus.er    = (state_q == ST_ERR);
    bus.busy  = (state_q != ST_INIT) && (state_q != ST_IDLE);
    bus.ack   = ack_sr_q[ACK_LAT-1];
`ifdef JOB_IRQ_EN
    bus.interrupt = (state_q == ST_END) || (state_q == ST_STOP) ||
                    ((state_q == ST_ERR) && (err_cnt_q == '0));
`else
    bus.interrupt = 1'b0;
`endif
  end

endmodule

// File: tb/tb_job_seq_ctrl.sv
// Scoreboard bench for job_seq_ctrl: expected output patterns are queued
// with their cycle numbers as stimulus is driven, then compared by a monitor.
module tb_job_seq_ctrl;

  localparam int RUN_CYCLES  = 8;
  localparam int COOL_CYCLES = 10;
  localparam int ERR_MAX     = 3;
  localparam int ACK_LAT     = 5;

  localparam logic [7:0] M_RDY = 8'h01, M_START = 8'h02, M_ENDD = 8'h04, M_STOP = 8'h08;
  localparam logic [7:0] M_ER  = 8'h10, M_IRQ   = 8'h20, M_ACK  = 8'h40, M_BUSY = 8'h80;
`ifdef JOB_IRQ_EN
  localparam logic [7:0] IRQV = M_IRQ;
`else
  localparam logic [7:0] IRQV = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  job_seq_ctrl_if ifc();

  job_seq_ctrl #(
    .RUN_CYCLES (RUN_CYCLES),
    .COOL_CYCLES(COOL_CYCLES),
    .ERR_MAX    (ERR_MAX),
    .ACK_LAT    (ACK_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  wire [7:0] obs = {ifc.busy, ifc.ack, ifc.interrupt, ifc.er,
                    ifc.stop, ifc.endd, ifc.start, ifc.rdy};

  typedef struct {
    int         cyc;
    logic [7:0] mask;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d observed=%02h expected=%02h", tag, cyc, o, e);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    logic a;
    #1;
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check_val(e.tag, obs & e.mask, e.val & e.mask);
    end
    a = 1'b0;
    while (ack_q.size() > 0 && ack_q[0] < cyc) begin
      void'(ack_q.pop_front());
      check_val("ack_missed_slot", 8'h00, 8'h01);
    end
    if (ack_q.size() > 0 && ack_q[0] == cyc) begin
      void'(ack_q.pop_front());
      a = 1'b1;
    end
    check_val("ack", {7'b0, ifc.ack}, {7'b0, a});
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int c, input logic [7:0] m, input logic [7:0] v, input string tag);
    exp_t e;
    e.cyc = c; e.mask = m; e.val = v; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && ifc.rdy !== 1'b1; i++) tick();
    check_val(tag, {7'b0, ifc.rdy}, 8'h01);
  endtask

  localparam logic [7:0] M_PULSE = M_START | M_ENDD | M_STOP | M_ER | M_RDY;

  initial begin
    int s, r, t0;
    ifc.go = 1'b0; ifc.abort = 1'b0; ifc.fault = 1'b0; ifc.req = 1'b0;
    #1 check_val("reset_outputs", obs, 8'h00);
    tick(); tick();
    rst = 1'b1;
    #1 check_val("init_rdy_low", obs & (M_RDY | M_BUSY), 8'h00);
    tick(); tick();
    check_val("idle_after_reset", obs & (M_RDY | M_BUSY | M_START), M_RDY);

    // T1: normal job, plus a go pulse during RUN that must be ignored
    ifc.go = 1'b1; s = cyc + 1;
    push(s, M_PULSE | M_BUSY, M_START | M_BUSY, "t1_start");
    for (int k = 1; k <= RUN_CYCLES; k++) push(s + k, M_PULSE | M_BUSY, M_BUSY, "t1_run");
    push(s + 9,  M_PULSE | M_IRQ, M_ENDD | IRQV, "t1_endd");
    push(s + 10, M_PULSE | M_IRQ | M_BUSY, M_BUSY, "t1_hold");
    tick(); ifc.go = 1'b0;
    run_to(s + 3); ifc.go = 1'b1; tick(); ifc.go = 1'b0;
    run_to(s + 10);
    wait_idle("t1_rdy_back", 8);
    check_val("t1_cool", {7'b0, (cyc - s) >= COOL_CYCLES}, 8'h01);

    // T2: abort in the third RUN cycle
    tick(); ifc.go = 1'b1; s = cyc + 1;
    push(s + 4, M_PULSE | M_IRQ, M_STOP | IRQV, "t2_stop");
    push(s + 5, M_PULSE | M_IRQ, 8'h00, "t2_after_stop");
    for (int k = 6; k <= 11; k++) push(s + k, M_ENDD | M_STOP, 8'h00, "t2_no_endd");
    tick(); ifc.go = 1'b0;
    run_to(s + 3); ifc.abort = 1'b1; tick(); ifc.abort = 1'b0;
    run_to(s + 11);
    wait_idle("t2_idle", 30);

    // T3: fault held 6 cycles in RUN, er capped at ERR_MAX cycles
    tick(); ifc.go = 1'b1; s = cyc + 1; r = s + 2;
    push(r + 1, M_PULSE | M_IRQ, M_ER | IRQV, "t3_er_first");
    push(r + 2, M_ER | M_IRQ, M_ER, "t3_er_hold");
    push(r + 3, M_ER | M_IRQ, M_ER, "t3_er_hold");
    push(r + 4, M_PULSE | M_BUSY, M_BUSY, "t3_er_drop");
    push(r + 5, M_ER, 8'h00, "t3_er_low");
    push(r + 6, M_ER, 8'h00, "t3_er_low");
    tick(); ifc.go = 1'b0;
    run_to(r); ifc.fault = 1'b1;
    run_to(r + 6); ifc.fault = 1'b0;
    wait_idle("t3_idle", 30);

    // T4: fault and abort together go to ERR, never STOP
    tick(); ifc.go = 1'b1; s = cyc + 1;
    push(s + 3, M_ER | M_STOP | M_IRQ, M_ER | IRQV, "t4_err");
    push(s + 4, M_ER | M_STOP, 8'h00, "t4_exit");
    tick(); ifc.go = 1'b0;
    run_to(s + 2); ifc.fault = 1'b1; ifc.abort = 1'b1;
    tick(); ifc.fault = 1'b0; ifc.abort = 1'b0;
    wait_idle("t4_idle", 30);

    // T4b: fault on the last RUN cycle wins over completion
    tick(); ifc.go = 1'b1; s = cyc + 1;
    push(s + 9,  M_ER | M_ENDD | M_IRQ, M_ER | IRQV, "t4b_last_fault");
    push(s + 10, M_ER | M_ENDD, 8'h00, "t4b_no_endd");
    tick(); ifc.go = 1'b0;
    run_to(s + RUN_CYCLES); ifc.fault = 1'b1;
    tick(); ifc.fault = 1'b0;
    wait_idle("t4b_idle", 30);

    // T5: req at t0, t0+1, t0+4; reset before t0+7 drops the third ack
    tick(); t0 = cyc;
    ack_q.push_back(t0 + ACK_LAT);
    ack_q.push_back(t0 + 1 + ACK_LAT);
    ifc.req = 1'b1; tick(); tick(); ifc.req = 1'b0;
    run_to(t0 + 4); ifc.req = 1'b1; tick(); ifc.req = 1'b0;
    run_to(t0 + 6); rst = 1'b0;
    #1 check_val("t5_rst_out", obs, 8'h00);
    tick(); tick(); rst = 1'b1;
    run_to(t0 + 11);
    wait_idle("t5_idle", 4);

    // T6: reset during RUN clears every output immediately
    tick(); ifc.go = 1'b1; s = cyc + 1;
    tick(); ifc.go = 1'b0;
    run_to(s + 3);
    check_val("t6_running", obs & (M_BUSY | M_RDY), M_BUSY);
    rst = 1'b0;
    #1 check_val("t6_rst_out", obs, 8'h00);
    tick();
    check_val("t6_rst_hold", obs, 8'h00);
    rst = 1'b1;
    #1 check_val("t6_init_low", obs, 8'h00);
    wait_idle("t6_idle", 4);
    check_val("t6_idle_busy", obs & (M_BUSY | M_START), 8'h00);

    tick(); tick();
    check_val("exp_q_drained", {7'b0, exp_q.size() == 0}, 8'h01);
    check_val("ack_q_drained", {7'b0, ack_q.size() == 0}, 8'h01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
